// File: rtl/sal_axi_arb_pkg.sv
// Shared types for the two-master AXI arbiter: master index, AR/AW payload
// layout and the position of the master tag bit inside the ID.
package sal_axi_arb_pkg;

    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int TAG_BIT        = AXI_ID_WIDTH - 1;

    typedef logic master_idx_t;

    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
    } ax_payload_t;

    localparam int AX_PAYLOAD_W = $bits(ax_payload_t);

    // Whatever the master put in the top ID bit is replaced by its port index.
    function automatic ax_payload_t tag_payload(ax_payload_t p, master_idx_t idx);
        ax_payload_t t;
        t = p;
        t.id[TAG_BIT] = idx;
        return t;
    endfunction

endpackage

// File: rtl/sal_axi_arb_slice.sv
// Round-robin arbiter for two address channels feeding a 1-entry register
// slice; used for both AR and AW.
module sal_axi_arb_slice
    import sal_axi_arb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    accept_en,
    input  logic                    m0_valid,
    input  logic [AX_PAYLOAD_W-1:0] m0_payload,
    output logic                    m0_ready,
    input  logic                    m1_valid,
    input  logic [AX_PAYLOAD_W-1:0] m1_payload,
    output logic                    m1_ready,
    output logic                    s_valid,
    output logic [AX_PAYLOAD_W-1:0] s_payload,
    input  logic                    s_ready
);

    master_idx_t rr_ptr;
    logic        slice_valid;
    ax_payload_t slice_payload;
    logic        can_accept;
    logic        grant;
    master_idx_t grant_idx;
    ax_payload_t sel_payload;

    // The slot frees up when empty or when its current entry is leaving this cycle.
    assign can_accept  = accept_en & (~slice_valid | s_ready);
    assign grant_idx   = (m0_valid & m1_valid) ? rr_ptr : m1_valid;
    assign grant       = can_accept & (m0_valid | m1_valid);
    assign m0_ready    = grant & ~grant_idx;
    assign m1_ready    = grant & grant_idx;
    assign sel_payload = grant_idx ? ax_payload_t'(m1_payload) : ax_payload_t'(m0_payload);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= 1'b0;
            slice_valid   <= 1'b0;
            slice_payload <= '0;
        end else if (grant) begin
            slice_valid   <= 1'b1;
            slice_payload <= tag_payload(sel_payload, grant_idx);
            rr_ptr        <= ~grant_idx;
        end else if (s_ready) begin
            slice_valid   <= 1'b0;
        end
    end

    assign s_valid   = slice_valid;
    assign s_payload = slice_payload;

endmodule

// File: rtl/sal_axi_arb.sv
// Two-master to one-slave AXI arbiter in front of the DDR controller: round-robin
// AR/AW with register slices, W steered in AW-grant order, R/B routed by ID tag.
module sal_axi_arb
    import sal_axi_arb_pkg::*;
#(
    parameter int ID_WIDTH        = AXI_ID_WIDTH,
    parameter int WORD_FIFO_DEPTH = 4,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      m0_arvalid,
    output logic                      m0_arready,
    input  logic [AXI_ADDR_WIDTH-1:0] m0_araddr,
    input  logic [ID_WIDTH-1:0]       m0_arid,
    input  logic [7:0]                m0_arlen,
    input  logic [2:0]                m0_arsize,
    input  logic [1:0]                m0_arburst,
    input  logic                      m0_awvalid,
    output logic                      m0_awready,
    input  logic [AXI_ADDR_WIDTH-1:0] m0_awaddr,
    input  logic [ID_WIDTH-1:0]       m0_awid,
    input  logic [7:0]                m0_awlen,
    input  logic [2:0]                m0_awsize,
    input  logic [1:0]                m0_awburst,
    input  logic                      m0_wvalid,
    output logic                      m0_wready,
    input  logic [DATA_WIDTH-1:0]     m0_wdata,
    input  logic [DATA_WIDTH/8-1:0]   m0_wstrb,
    input  logic                      m0_wlast,
    output logic                      m0_rvalid,
    input  logic                      m0_rready,
    output logic [ID_WIDTH-1:0]       m0_rid,
    output logic [DATA_WIDTH-1:0]     m0_rdata,
    output logic [1:0]                m0_rresp,
    output logic                      m0_rlast,
    output logic                      m0_bvalid,
    input  logic                      m0_bready,
    output logic [ID_WIDTH-1:0]       m0_bid,
    output logic [1:0]                m0_bresp,

    input  logic                      m1_arvalid,
    output logic                      m1_arready,
    input  logic [AXI_ADDR_WIDTH-1:0] m1_araddr,
    input  logic [ID_WIDTH-1:0]       m1_arid,
    input  logic [7:0]                m1_arlen,
    input  logic [2:0]                m1_arsize,
    input  logic [1:0]                m1_arburst,
    input  logic                      m1_awvalid,
    output logic                      m1_awready,
    input  logic [AXI_ADDR_WIDTH-1:0] m1_awaddr,
    input  logic [ID_WIDTH-1:0]       m1_awid,
    input  logic [7:0]                m1_awlen,
    input  logic [2:0]                m1_awsize,
    input  logic [1:0]                m1_awburst,
    input  logic                      m1_wvalid,
    output logic                      m1_wready,
    input  logic [DATA_WIDTH-1:0]     m1_wdata,
    input  logic [DATA_WIDTH/8-1:0]   m1_wstrb,
    input  logic                      m1_wlast,
    output logic                      m1_rvalid,
    input  logic                      m1_rready,
    output logic [ID_WIDTH-1:0]       m1_rid,
    output logic [DATA_WIDTH-1:0]     m1_rdata,
    output logic [1:0]                m1_rresp,
    output logic                      m1_rlast,
    output logic                      m1_bvalid,
    input  logic                      m1_bready,
    output logic [ID_WIDTH-1:0]       m1_bid,
    output logic [1:0]                m1_bresp,

    output logic                      s_arvalid,
    input  logic                      s_arready,
    output logic [AXI_ADDR_WIDTH-1:0] s_araddr,
    output logic [ID_WIDTH-1:0]       s_arid,
    output logic [7:0]                s_arlen,
    output logic [2:0]                s_arsize,
    output logic [1:0]                s_arburst,
    output logic                      s_awvalid,
    input  logic                      s_awready,
    output logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
    output logic [ID_WIDTH-1:0]       s_awid,
    output logic [7:0]                s_awlen,
    output logic [2:0]                s_awsize,
    output logic [1:0]                s_awburst,
    output logic                      s_wvalid,
    input  logic                      s_wready,
    output logic [DATA_WIDTH-1:0]     s_wdata,
    output logic [DATA_WIDTH/8-1:0]   s_wstrb,
    output logic                      s_wlast,
    input  logic                      s_rvalid,
    output logic                      s_rready,
    input  logic [ID_WIDTH-1:0]       s_rid,
    input  logic [DATA_WIDTH-1:0]     s_rdata,
    input  logic [1:0]                s_rresp,
    input  logic                      s_rlast,
    input  logic                      s_bvalid,
    output logic                      s_bready,
    input  logic [ID_WIDTH-1:0]       s_bid,
    input  logic [1:0]                s_bresp
);

    localparam int PTR_W = $clog2(WORD_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FIFO_FULL_COUNT = CNT_W'(WORD_FIFO_DEPTH);

    ax_payload_t m0_ar_p, m1_ar_p, s_ar_p;
    ax_payload_t m0_aw_p, m1_aw_p, s_aw_p;
    logic [AX_PAYLOAD_W-1:0] s_ar_vec, s_aw_vec;

    assign m0_ar_p = '{addr: m0_araddr, id: m0_arid, len: m0_arlen, size: m0_arsize, burst: m0_arburst};
    assign m1_ar_p = '{addr: m1_araddr, id: m1_arid, len: m1_arlen, size: m1_arsize, burst: m1_arburst};
    assign m0_aw_p = '{addr: m0_awaddr, id: m0_awid, len: m0_awlen, size: m0_awsize, burst: m0_awburst};
    assign m1_aw_p = '{addr: m1_awaddr, id: m1_awid, len: m1_awlen, size: m1_awsize, burst: m1_awburst};

    sal_axi_arb_slice u_ar_slice (
        .clk        (clk),
        .rst        (rst),
        .accept_en  (1'b1),
        .m0_valid   (m0_arvalid),
        .m0_payload (m0_ar_p),
        .m0_ready   (m0_arready),
        .m1_valid   (m1_arvalid),
        .m1_payload (m1_ar_p),
        .m1_ready   (m1_arready),
        .s_valid    (s_arvalid),
        .s_payload  (s_ar_vec),
        .s_ready    (s_arready)
    );

    logic        fifo_full;
    logic        fifo_empty;
    logic        aw_accept_en;
    logic        w_pop;
    logic        aw_push;
    master_idx_t aw_push_idx;

    sal_axi_arb_slice u_aw_slice (
        .clk        (clk),
        .rst        (rst),
        .accept_en  (aw_accept_en),
        .m0_valid   (m0_awvalid),
        .m0_payload (m0_aw_p),
        .m0_ready   (m0_awready),
        .m1_valid   (m1_awvalid),
        .m1_payload (m1_aw_p),
        .m1_ready   (m1_awready),
        .s_valid    (s_awvalid),
        .s_payload  (s_aw_vec),
        .s_ready    (s_awready)
    );

    assign s_ar_p    = s_ar_vec;
    assign s_araddr  = s_ar_p.addr;
    assign s_arid    = s_ar_p.id;
    assign s_arlen   = s_ar_p.len;
    assign s_arsize  = s_ar_p.size;
    assign s_arburst = s_ar_p.burst;
    assign s_aw_p    = s_aw_vec;
    assign s_awaddr  = s_aw_p.addr;
    assign s_awid    = s_aw_p.id;
    assign s_awlen   = s_aw_p.len;
    assign s_awsize  = s_aw_p.size;
    assign s_awburst = s_aw_p.burst;

    // Write-order FIFO: one entry per granted AW whose W burst has not finished.
    logic [WORD_FIFO_DEPTH-1:0] order_mem;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    master_idx_t                head;

    assign fifo_full    = (count == FIFO_FULL_COUNT);
    assign fifo_empty   = (count == '0);
    assign head         = order_mem[rd_ptr];
    assign aw_push      = m0_awready | m1_awready;
    assign aw_push_idx  = m1_awready;
    assign w_pop        = s_wvalid & s_wready & s_wlast;
    // A finishing burst frees its slot in the same cycle, so a full FIFO can still take a grant.
    assign aw_accept_en = ~fifo_full | w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (aw_push) begin
                order_mem[wr_ptr] <= aw_push_idx;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (w_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({aw_push, w_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign s_wvalid  = ~fifo_empty & (head ? m1_wvalid : m0_wvalid);
    assign s_wdata   = head ? m1_wdata : m0_wdata;
    assign s_wstrb   = head ? m1_wstrb : m0_wstrb;
    assign s_wlast   = head ? m1_wlast : m0_wlast;
    assign m0_wready = ~fifo_empty & ~head & s_wready;
    assign m1_wready = ~fifo_empty &  head & s_wready;

    // Responses go back to whichever master the tag bit of the returned ID names.
    logic r_tgt;
    logic b_tgt;

    assign r_tgt     = s_rid[ID_WIDTH-1];
    assign m0_rvalid = s_rvalid & ~r_tgt;
    assign m1_rvalid = s_rvalid &  r_tgt;
    assign s_rready  = r_tgt ? m1_rready : m0_rready;
    assign m0_rid    = {1'b0, s_rid[ID_WIDTH-2:0]};
    assign m1_rid    = {1'b0, s_rid[ID_WIDTH-2:0]};
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m1_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m1_rlast  = s_rlast;

    assign b_tgt     = s_bid[ID_WIDTH-1];
    assign m0_bvalid = s_bvalid & ~b_tgt;
    assign m1_bvalid = s_bvalid &  b_tgt;
    assign s_bready  = b_tgt ? m1_bready : m0_bready;
    assign m0_bid    = {1'b0, s_bid[ID_WIDTH-2:0]};
    assign m1_bid    = {1'b0, s_bid[ID_WIDTH-2:0]};
    assign m0_bresp  = s_bresp;
    assign m1_bresp  = s_bresp;

    a_m0_arid_tag: assert property (@(posedge clk) disable iff (rst)
        (m0_arvalid && m0_arready) |-> !m0_arid[ID_WIDTH-1]);
    a_m1_arid_tag: assert property (@(posedge clk) disable iff (rst)
        (m1_arvalid && m1_arready) |-> !m1_arid[ID_WIDTH-1]);
    a_m0_awid_tag: assert property (@(posedge clk) disable iff (rst)
        (m0_awvalid && m0_awready) |-> !m0_awid[ID_WIDTH-1]);
    a_m1_awid_tag: assert property (@(posedge clk) disable iff (rst)
        (m1_awvalid && m1_awready) |-> !m1_awid[ID_WIDTH-1]);

endmodule

// File: tb/tb_sal_axi_arb.sv
// Directed self-checking bench for sal_axi_arb: one task per scenario, inline
// comparisons against hand-computed values.
module tb_sal_axi_arb;

    logic        clk = 1'b0;
    logic        rst;

    logic        m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    logic [31:0] m0_araddr, m1_araddr;
    logic [3:0]  m0_arid, m1_arid;
    logic [7:0]  m0_arlen, m1_arlen;
    logic [2:0]  m0_arsize, m1_arsize;
    logic [1:0]  m0_arburst, m1_arburst;
    logic        m0_awvalid, m0_awready, m1_awvalid, m1_awready;
    logic [31:0] m0_awaddr, m1_awaddr;
    logic [3:0]  m0_awid, m1_awid;
    logic [7:0]  m0_awlen, m1_awlen;
    logic [2:0]  m0_awsize, m1_awsize;
    logic [1:0]  m0_awburst, m1_awburst;
    logic        m0_wvalid, m0_wready, m1_wvalid, m1_wready;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_wlast, m1_wlast;
    logic        m0_rvalid, m0_rready, m1_rvalid, m1_rready;
    logic [3:0]  m0_rid, m1_rid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic        m0_rlast, m1_rlast;
    logic        m0_bvalid, m0_bready, m1_bvalid, m1_bready;
    logic [3:0]  m0_bid, m1_bid;
    logic [1:0]  m0_bresp, m1_bresp;

    logic        s_arvalid, s_arready;
    logic [31:0] s_araddr;
    logic [3:0]  s_arid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_awvalid, s_awready;
    logic [31:0] s_awaddr;
    logic [3:0]  s_awid;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_rvalid, s_rready;
    logic [3:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_bvalid, s_bready;
    logic [3:0]  s_bid;
    logic [1:0]  s_bresp;

    int checks = 0;
    int errors = 0;

    sal_axi_arb #(.ID_WIDTH(4), .WORD_FIFO_DEPTH(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr), .m0_awid(m0_awid),
        .m0_awlen(m0_awlen), .m0_awsize(m0_awsize), .m0_awburst(m0_awburst),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rid(m0_rid), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bid(m0_bid), .m0_bresp(m0_bresp),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
        .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rid(m1_rid), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bid(m1_bid), .m1_bresp(m1_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp)
    );

    always #5 clk = ~clk;

    task automatic idle_all();
        m0_arvalid = 0; m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = 3'd2; m0_arburst = 2'd1;
        m1_arvalid = 0; m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = 3'd2; m1_arburst = 2'd1;
        m0_awvalid = 0; m0_awaddr = '0; m0_awid = '0; m0_awlen = '0; m0_awsize = 3'd2; m0_awburst = 2'd1;
        m1_awvalid = 0; m1_awaddr = '0; m1_awid = '0; m1_awlen = '0; m1_awsize = 3'd2; m1_awburst = 2'd1;
        m0_wvalid = 0; m0_wdata = '0; m0_wstrb = 4'hF; m0_wlast = 0;
        m1_wvalid = 0; m1_wdata = '0; m1_wstrb = 4'hF; m1_wlast = 0;
        m0_rready = 0; m1_rready = 0; m0_bready = 0; m1_bready = 0;
        s_arready = 0; s_awready = 0; s_wready = 0;
        s_rvalid = 0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 0;
        s_bvalid = 0; s_bid = '0; s_bresp = '0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (s_arvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_arvalid got %b exp 0", s_arvalid); end
        checks++; if (s_awvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_awvalid got %b exp 0", s_awvalid); end
        checks++; if (s_wvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_wvalid got %b exp 0", s_wvalid); end
        checks++; if ({m0_rvalid, m1_rvalid, m0_bvalid, m1_bvalid} !== 4'b0) begin errors++; $display("[TB] FAIL reset_resp_valids got %b exp 0000", {m0_rvalid, m1_rvalid, m0_bvalid, m1_bvalid}); end
        @(posedge clk); #1;
        rst = 0;
        m0_arvalid = 1; m1_arvalid = 1; m0_wvalid = 1; m0_wlast = 1;
        @(negedge clk);
        checks++; if ({m0_arready, m1_arready} !== 2'b10) begin errors++; $display("[TB] FAIL reset_tie_grant got %b exp 10", {m0_arready, m1_arready}); end
        checks++; if ({s_wvalid, m0_wready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_fifo_empty got %b exp 00", {s_wvalid, m0_wready}); end
        idle_all();
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        m1_arvalid = 1; m1_araddr = 32'h1000; m1_arid = 4'd3; m1_arlen = 8'd3;
        @(negedge clk);
        checks++; if ({m1_arready, s_arvalid} !== 2'b10) begin errors++; $display("[TB] FAIL read_m1_handshake got %b exp 10", {m1_arready, s_arvalid}); end
        @(posedge clk); #1;
        m1_arvalid = 0;
        @(negedge clk);
        checks++; if (s_arvalid !== 1'b1) begin errors++; $display("[TB] FAIL read_s_arvalid got %b exp 1", s_arvalid); end
        checks++; if (s_arid !== 4'b1011) begin errors++; $display("[TB] FAIL read_s_arid got %b exp 1011", s_arid); end
        checks++; if ({s_araddr, s_arlen} !== {32'h1000, 8'd3}) begin errors++; $display("[TB] FAIL read_s_payload got %h/%0d exp 1000/3", s_araddr, s_arlen); end
        s_arready = 1;
        @(posedge clk); #1;
        s_arready = 0;
        m1_rready = 1;
        for (int b = 0; b < 4; b++) begin
            s_rvalid = 1; s_rid = 4'b1011; s_rdata = 32'hD0 + b; s_rlast = (b == 3);
            @(negedge clk);
            checks++; if ({m1_rvalid, m0_rvalid, s_rready} !== 3'b101) begin errors++; $display("[TB] FAIL read_beat%0d_valids got %b exp 101", b, {m1_rvalid, m0_rvalid, s_rready}); end
            checks++; if (m1_rid !== 4'd3) begin errors++; $display("[TB] FAIL read_beat%0d_rid got %0d exp 3", b, m1_rid); end
            checks++; if ({m1_rdata, m1_rlast} !== {32'hD0 + b, (b == 3)}) begin errors++; $display("[TB] FAIL read_beat%0d_data got %h/%b exp %h/%b", b, m1_rdata, m1_rlast, 32'hD0 + b, (b == 3)); end
            @(posedge clk); #1;
        end
        s_rvalid = 0; s_rlast = 0; m1_rready = 0;
        @(negedge clk);
        checks++; if (s_arvalid !== 1'b0) begin errors++; $display("[TB] FAIL read_slice_drained got %b exp 0", s_arvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        int          k0 = 0;
        int          k1 = 0;
        int          grants = 0;
        logic [31:0] prev_addr = '0;
        logic [3:0]  prev_id = '0;
        logic        g;
        s_arready = 1;
        m0_arvalid = 1; m0_araddr = 32'h2000; m0_arid = 4'd1;
        m1_arvalid = 1; m1_araddr = 32'h3000; m1_arid = 4'd2;
        for (int i = 0; i < 16; i++) begin
            g = i[0];
            @(negedge clk);
            checks++; if ({m0_arready, m1_arready} !== {~g, g}) begin errors++; $display("[TB] FAIL contention_grant%0d got %b exp %b", i, {m0_arready, m1_arready}, {~g, g}); end
            if (m0_arready | m1_arready) grants++;
            if (i > 0) begin
                checks++; if ({s_arvalid, s_araddr, s_arid} !== {1'b1, prev_addr, prev_id}) begin errors++; $display("[TB] FAIL contention_out%0d got %b/%h/%b exp 1/%h/%b", i, s_arvalid, s_araddr, s_arid, prev_addr, prev_id); end
            end
            @(posedge clk); #1;
            if (!g) begin
                prev_addr = 32'h2000 + k0; prev_id = 4'b0001; k0++;
                m0_araddr = 32'h2000 + k0;
                if (k0 == 8) m0_arvalid = 0;
            end else begin
                prev_addr = 32'h3000 + k1; prev_id = 4'b1010; k1++;
                m1_araddr = 32'h3000 + k1;
                if (k1 == 8) m1_arvalid = 0;
            end
        end
        @(negedge clk);
        checks++; if ({s_arvalid, s_araddr, s_arid} !== {1'b1, 32'h3007, 4'b1010}) begin errors++; $display("[TB] FAIL contention_last got %b/%h/%b exp 1/3007/1010", s_arvalid, s_araddr, s_arid); end
        checks++; if (grants !== 16) begin errors++; $display("[TB] FAIL contention_count got %0d exp 16", grants); end
        @(posedge clk); #1;
        s_arready = 0;
        @(negedge clk);
        checks++; if (s_arvalid !== 1'b0) begin errors++; $display("[TB] FAIL contention_drained got %b exp 0", s_arvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_write_order();
        s_awready = 1; s_wready = 1;
        m0_awvalid = 1; m0_awaddr = 32'hA000; m0_awid = 4'd0; m0_awlen = 8'd1;
        m1_wvalid = 1; m1_wdata = 32'hB0; m1_wlast = 1;
        @(negedge clk);
        checks++; if ({m0_awready, m1_wready, s_wvalid} !== 3'b100) begin errors++; $display("[TB] FAIL worder_aw0 got %b exp 100", {m0_awready, m1_wready, s_wvalid}); end
        @(posedge clk); #1;
        m0_awvalid = 0;
        m1_awvalid = 1; m1_awaddr = 32'hB000; m1_awid = 4'd0; m1_awlen = 8'd0;
        @(negedge clk);
        checks++; if ({m1_awready, m1_wready, s_wvalid} !== 3'b100) begin errors++; $display("[TB] FAIL worder_aw1 got %b exp 100", {m1_awready, m1_wready, s_wvalid}); end
        checks++; if ({s_awvalid, s_awid, s_awlen} !== {1'b1, 4'b0000, 8'd1}) begin errors++; $display("[TB] FAIL worder_s_aw0 got %b/%b/%0d exp 1/0000/1", s_awvalid, s_awid, s_awlen); end
        @(posedge clk); #1;
        m1_awvalid = 0;
        m0_wvalid = 1; m0_wdata = 32'hA0; m0_wlast = 0;
        @(negedge clk);
        checks++; if ({s_awvalid, s_awid} !== {1'b1, 4'b1000}) begin errors++; $display("[TB] FAIL worder_s_aw1 got %b/%b exp 1/1000", s_awvalid, s_awid); end
        checks++; if ({s_wvalid, s_wdata, s_wlast, m0_wready, m1_wready} !== {1'b1, 32'hA0, 1'b0, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL worder_beat0 got %b/%h/%b/%b/%b exp 1/a0/0/1/0", s_wvalid, s_wdata, s_wlast, m0_wready, m1_wready); end
        @(posedge clk); #1;
        m0_wdata = 32'hA1; m0_wlast = 1;
        @(negedge clk);
        checks++; if ({s_wvalid, s_wdata, s_wlast, m0_wready, m1_wready} !== {1'b1, 32'hA1, 1'b1, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL worder_beat1 got %b/%h/%b/%b/%b exp 1/a1/1/1/0", s_wvalid, s_wdata, s_wlast, m0_wready, m1_wready); end
        @(posedge clk); #1;
        m0_wvalid = 0; m0_wlast = 0;
        @(negedge clk);
        checks++; if ({s_wvalid, s_wdata, s_wlast, m0_wready, m1_wready} !== {1'b1, 32'hB0, 1'b1, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL worder_beat2 got %b/%h/%b/%b/%b exp 1/b0/1/0/1", s_wvalid, s_wdata, s_wlast, m0_wready, m1_wready); end
        @(posedge clk); #1;
        m1_wvalid = 0; m1_wlast = 0;
        s_bvalid = 1; s_bid = 4'b1000; s_bresp = 2'd0; m1_bready = 1;
        @(negedge clk);
        checks++; if (s_wvalid !== 1'b0) begin errors++; $display("[TB] FAIL worder_done got %b exp 0", s_wvalid); end
        checks++; if ({m1_bvalid, m0_bvalid, m1_bid, s_bready} !== {1'b1, 1'b0, 4'd0, 1'b1}) begin errors++; $display("[TB] FAIL worder_bresp got %b/%b/%0d/%b exp 1/0/0/1", m1_bvalid, m0_bvalid, m1_bid, s_bready); end
        @(posedge clk); #1;
        s_bvalid = 0; m1_bready = 0;
    endtask

    task automatic test_fifo_full();
        s_awready = 1; s_wready = 1;
        m0_awvalid = 1; m0_awaddr = 32'hC000; m0_awid = 4'd2; m0_awlen = 8'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (m0_awready !== 1'b1) begin errors++; $display("[TB] FAIL full_aw%0d got %b exp 1", i, m0_awready); end
            @(posedge clk); #1;
            m0_awaddr = m0_awaddr + 32'h10;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (m0_awready !== 1'b0) begin errors++; $display("[TB] FAIL full_blocked%0d got %b exp 0", i, m0_awready); end
            @(posedge clk); #1;
        end
        m0_wvalid = 1; m0_wdata = 32'h55; m0_wlast = 1;
        @(negedge clk);
        checks++; if ({s_wvalid, m0_wready, m0_awready} !== 3'b111) begin errors++; $display("[TB] FAIL full_pop_push got %b exp 111", {s_wvalid, m0_wready, m0_awready}); end
        @(posedge clk); #1;
        m0_awvalid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (m0_wready !== 1'b1) begin errors++; $display("[TB] FAIL full_drain%0d got %b exp 1", i, m0_wready); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if ({s_wvalid, m0_wready} !== 2'b00) begin errors++; $display("[TB] FAIL full_empty got %b exp 00", {s_wvalid, m0_wready}); end
        idle_all();
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        s_arready = 0;
        m0_arvalid = 1; m0_araddr = 32'h4444; m0_arid = 4'd5; m0_arlen = 8'd7;
        @(negedge clk);
        checks++; if (m0_arready !== 1'b1) begin errors++; $display("[TB] FAIL bp_accept got %b exp 1", m0_arready); end
        @(posedge clk); #1;
        m0_araddr = 32'h5555;
        m1_arvalid = 1; m1_araddr = 32'h6666; m1_arid = 4'd2; m1_arlen = 8'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if ({s_arvalid, s_araddr, s_arid, s_arlen} !== {1'b1, 32'h4444, 4'b0101, 8'd7}) begin errors++; $display("[TB] FAIL bp_hold%0d got %b/%h/%b/%0d exp 1/4444/0101/7", i, s_arvalid, s_araddr, s_arid, s_arlen); end
            checks++; if ({m0_arready, m1_arready} !== 2'b00) begin errors++; $display("[TB] FAIL bp_noready%0d got %b exp 00", i, {m0_arready, m1_arready}); end
            @(posedge clk); #1;
        end
        s_arready = 1;
        @(negedge clk);
        checks++; if ({m0_arready, m1_arready} !== 2'b01) begin errors++; $display("[TB] FAIL bp_release got %b exp 01", {m0_arready, m1_arready}); end
        @(posedge clk); #1;
        m0_arvalid = 0; m1_arvalid = 0;
        @(negedge clk);
        checks++; if ({s_arvalid, s_araddr, s_arid} !== {1'b1, 32'h6666, 4'b1010}) begin errors++; $display("[TB] FAIL bp_next got %b/%h/%b exp 1/6666/1010", s_arvalid, s_araddr, s_arid); end
        @(posedge clk); #1;
        s_arready = 0;
    endtask

    task automatic test_reset_mid();
        s_arready = 0; s_awready = 1; s_wready = 0;
        m0_arvalid = 1; m0_araddr = 32'h7000; m0_arid = 4'd0;
        m1_arvalid = 1; m1_araddr = 32'h8000; m1_arid = 4'd1;
        m0_awvalid = 1; m0_awaddr = 32'h9000; m0_awlen = 8'd0;
        @(negedge clk);
        checks++; if ({m0_arready, m1_arready, m0_awready} !== 3'b101) begin errors++; $display("[TB] FAIL rmid_setup0 got %b exp 101", {m0_arready, m1_arready, m0_awready}); end
        @(posedge clk); #1;
        m0_arvalid = 0;
        @(negedge clk);
        checks++; if ({s_arvalid, m1_arready, m0_awready} !== 3'b101) begin errors++; $display("[TB] FAIL rmid_setup1 got %b exp 101", {s_arvalid, m1_arready, m0_awready}); end
        @(posedge clk); #1;
        m0_awvalid = 0; m0_arvalid = 1;
        m0_wvalid = 1; m0_wlast = 1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checks++; if ({s_arvalid, s_awvalid, s_wvalid} !== 3'b000) begin errors++; $display("[TB] FAIL rmid_valids got %b exp 000", {s_arvalid, s_awvalid, s_wvalid}); end
        checks++; if (m0_wready !== 1'b0) begin errors++; $display("[TB] FAIL rmid_fifo_empty got %b exp 0", m0_wready); end
        checks++; if ({m0_arready, m1_arready} !== 2'b10) begin errors++; $display("[TB] FAIL rmid_rr_ptr got %b exp 10", {m0_arready, m1_arready}); end
        idle_all();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write_order();
        test_fifo_full();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
